// File: rtl/vga_timing_generator.sv
// 640x480@60 raster scanner: counters (stage 0), coordinates/sync decode (stage 1), pins (stage 2).
// Optional VGA_TEST_PATTERN_EN adds a test_mode input that replaces color with 8 vertical colour bars.
module vga_timing_generator #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_tick
);

  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] H_LAST   = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_LAST   = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [11:0] h_cnt, v_cnt;
  logic        active_c, hs_c, vs_c, tick_c;
  logic        active_d, hs_d, vs_d;
  logic [2:0]  pix;

  // stage 0: raster counters
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    active_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_c     = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    vs_c     = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    tick_c   = (h_cnt == 12'd0) && (v_cnt == V_VIS);
  end

  // stage 1: 1-based coordinates feed img_generator, decoded sync held for stage 2
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      x          <= '0;
      y          <= '0;
      active_d   <= 1'b0;
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      x          <= active_c ? h_cnt + 12'd1 : 12'd0;
      y          <= active_c ? v_cnt + 12'd1 : 12'd0;
      active_d   <= active_c;
      hs_d       <= hs_c;
      vs_d       <= vs_c;
      frame_tick <= tick_c;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_VISIBLE / 8);
  logic [11:0] x_m1, bar;
  // x-1 wraps when x=0, but that pixel is blanked so the bar index is don't-care
  always_comb begin
    x_m1 = x - 12'd1;
    bar  = x_m1 / BAR_W;
    pix  = test_mode ? bar[2:0] : color;
  end
`else
  always_comb pix = color;
`endif

  // stage 2: colour sampled against the stage-1 x/y, all pins from the same stage-1 state
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      {vga_r, vga_g, vga_b} <= 3'b000;
      blank_n <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else begin
      {vga_r, vga_g, vga_b} <= active_d ? pix : 3'b000;
      blank_n <= active_d;
      hsync   <= hs_d ? SYNC_POL : ~SYNC_POL;
      vsync   <= vs_d ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: full-size instance for line timing, shrunken instance (16x9 raster) for frame timing.
module tb_vga_timing_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  color = 3'b101;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  logic [11:0] dx, dy, sx, sy;
  logic        dr, dg, db, dhs, dvs, dbn, dft;
  logic        sr, sg, sb_, shs, svs, sbn, sft;

  always #5 clk = ~clk;

  vga_timing_generator dut (
    .CLOCK_25(clk), .RESET_N(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .color(color), .x(dx), .y(dy), .vga_r(dr), .vga_g(dg), .vga_b(db),
    .hsync(dhs), .vsync(dvs), .blank_n(dbn), .frame_tick(dft)
  );

  // small raster: H total 16 (vis 8, sync at h 10..12), V total 9 (vis 4, sync at v 5..6)
  vga_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
  ) dsm (
    .CLOCK_25(clk), .RESET_N(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .color(color), .x(sx), .y(sy), .vga_r(sr), .vga_g(sg), .vga_b(sb_),
    .hsync(shs), .vsync(svs), .blank_n(sbn), .frame_tick(sft)
  );

  typedef struct { int cyc; int sel; int val; } ent_t;
  ent_t sb[$];
  int cnt = 0;
  int n_vec = 0;
  int n_bad = 0;

  function automatic int sig(int sel);
    case (sel)
      0: return int'(dx);   1: return int'(dy);   2: return int'({dr, dg, db});
      3: return int'(dhs);  4: return int'(dvs);  5: return int'(dbn);  6: return int'(dft);
      10: return int'(sx);  11: return int'(sy);  12: return int'({sr, sg, sb_});
      13: return int'(shs); 14: return int'(svs); 15: return int'(sbn); 16: return int'(sft);
      default: return -1;
    endcase
  endfunction

  function automatic string nm(int sel);
    string base[7] = '{"x", "y", "rgb", "hsync", "vsync", "blank_n", "frame_tick"};
    return {(sel >= 10) ? "small." : "full.", base[sel % 10]};
  endfunction

  task automatic ex(int c, int sel, int v);
    sb.push_back('{c, sel, v});
  endtask

  task automatic ex_reset(int c);
    for (int k = 0; k < 20; k += 10) begin
      ex(c, k+0, 0); ex(c, k+1, 0); ex(c, k+2, 0); ex(c, k+3, 1);
      ex(c, k+4, 1); ex(c, k+5, 0); ex(c, k+6, 0);
    end
  endtask

  task automatic wait_until(int n);
    do begin @(negedge clk); #1; end while (cnt < n);
  endtask

  // monitor: every negedge, compare all entries due now; anything overdue is a miss
  initial begin
    forever begin
      @(negedge clk);
      cnt++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cnt) begin
          n_vec++; n_bad++;
          $display("FAIL %s @%0d: never sampled, required %0d", nm(sb[i].sel), sb[i].cyc, sb[i].val);
          sb.delete(i);
        end else if (sb[i].cyc == cnt) begin
          n_vec++;
          if (sig(sb[i].sel) != sb[i].val) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0d, required %0d", nm(sb[i].sel), cnt, sig(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int r, r2;
    ex_reset(2);
    wait_until(4);
    rst_n = 1'b1;
    r = cnt;

    // full-size line timing: sample at r+c follows the c-th edge after release
    ex(r+1, 0, 1);     ex(r+1, 1, 1);     ex(r+640, 0, 640); ex(r+641, 0, 0);
    ex(r+800, 0, 0);   ex(r+801, 0, 1);   ex(r+801, 1, 2);
    ex(r+1, 5, 0);     ex(r+2, 5, 1);     ex(r+641, 5, 1);   ex(r+642, 5, 0);
    ex(r+1, 2, 0);     ex(r+2, 2, 5);     ex(r+400, 2, 5);   ex(r+401, 2, 2);  ex(r+642, 2, 0);
    ex(r+657, 3, 1);   ex(r+658, 3, 0);   ex(r+753, 3, 0);   ex(r+754, 3, 1);
    ex(r+1457, 3, 1);  ex(r+1458, 3, 0);  ex(r+1553, 3, 0);  ex(r+1554, 3, 1);
    ex(r+700, 4, 1);   ex(r+1600, 4, 1);  ex(r+500, 6, 0);

    // small raster: line 16 clk, frame 144 clk
    ex(r+1, 10, 1);    ex(r+8, 10, 8);    ex(r+9, 10, 0);    ex(r+17, 10, 1);  ex(r+17, 11, 2);
    ex(r+56, 10, 8);   ex(r+56, 11, 4);   ex(r+144, 10, 0);  ex(r+145, 10, 1); ex(r+145, 11, 1);
    ex(r+11, 13, 1);   ex(r+12, 13, 0);   ex(r+14, 13, 0);   ex(r+15, 13, 1);  ex(r+28, 13, 0);
    ex(r+81, 14, 1);   ex(r+82, 14, 0);   ex(r+113, 14, 0);  ex(r+114, 14, 1);
    ex(r+225, 14, 1);  ex(r+226, 14, 0);
    ex(r+64, 16, 0);   ex(r+65, 16, 1);   ex(r+66, 16, 0);   ex(r+209, 16, 1); ex(r+210, 16, 0);
    ex(r+2, 15, 1);    ex(r+9, 15, 1);    ex(r+10, 15, 0);   ex(r+66, 15, 0);
    ex(r+9, 12, 5);    ex(r+10, 12, 0);

    // state just before the mid-frame reset
    ex(r+1640, 0, 40); ex(r+1640, 1, 3);  ex(r+1640, 5, 1);  ex(r+1640, 2, 2);  ex(r+1640, 3, 1);
    ex(r+1640, 10, 8); ex(r+1640, 11, 4);

    wait_until(r+400);
    color = 3'b010;
    wait_until(r+1640);

    // async reset between edges: next sample precedes any further posedge
    @(posedge clk); #1;
    rst_n = 1'b0;
    ex_reset(cnt+1);
    wait_until(cnt+3);
    rst_n = 1'b1;
    r2 = cnt;

    ex(r2+1, 0, 1);    ex(r2+1, 1, 1);    ex(r2+640, 0, 640); ex(r2+641, 0, 0);
    ex(r2+1, 5, 0);    ex(r2+2, 5, 1);    ex(r2+657, 3, 1);   ex(r2+658, 3, 0);
    ex(r2+1, 10, 1);   ex(r2+65, 16, 1);  ex(r2+82, 14, 0);

    wait_until(r2+700);
    if (sb.size() != 0) begin
      n_vec += sb.size();
      n_bad += sb.size();
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
